// File: rtl/otp_xor.sv
// Streams one block of data and pad nibbles from RAM, XORs them and writes the result to a processed RAM.
// Optional build macro OTP_XOR_CHECKSUM_EN adds a running XOR checksum of the written nibbles.
module otp_xor #(
   parameter int ADDR_W    = 10,
   parameter int LAST_ADDR = 1023
) (
   input  logic              irst,
   input  logic              iclk,
   input  logic              istart,
   output logic [ADDR_W-1:0] oaddr,
   input  logic [3:0]        idata,
   input  logic [3:0]        ipad,
   output logic [ADDR_W-1:0] owaddr,
   output logic [3:0]        owdata,
   output logic              owrite_en,
   output logic              obusy,
   output logic              odone,
   output logic [3:0]        ochecksum
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

   state_t            state_r;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_next;
   logic              wen_next;
   logic              busy_next;
   logic              done_next;

   // Next-state and next-output decode; a write is scheduled for every RUN cycle
   always_comb begin
      state_next = state_r;
      addr_next  = oaddr;
      wen_next   = 1'b0;
      busy_next  = obusy;
      done_next  = 1'b0;
      case (state_r)
         IDLE: begin
            addr_next = {ADDR_W{1'b0}};
            if (istart) begin
               state_next = RUN;
               busy_next  = 1'b1;
            end else begin
               busy_next  = 1'b0;
            end
         end
         RUN: begin
            wen_next = 1'b1;
            if (oaddr == LAST) begin
               state_next = FLUSH;
            end else begin
               addr_next = oaddr + ADDR_W'(1);
            end
         end
         FLUSH: begin
            state_next = DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
         end
         DONE: begin
            state_next = IDLE;
            addr_next  = {ADDR_W{1'b0}};
         end
         default: begin
            state_next = IDLE;
            addr_next  = {ADDR_W{1'b0}};
            busy_next  = 1'b0;
         end
      endcase
   end

   // State and control output registers
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_r   <= IDLE;
         oaddr     <= {ADDR_W{1'b0}};
         owrite_en <= 1'b0;
         obusy     <= 1'b0;
         odone     <= 1'b0;
      end else begin
         state_r   <= state_next;
         oaddr     <= addr_next;
         owrite_en <= wen_next;
         obusy     <= busy_next;
         odone     <= done_next;
      end
   end

   // Write address/data capture; idata/ipad belong to the address currently on oaddr
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         owaddr <= {ADDR_W{1'b0}};
         owdata <= 4'h0;
      end else if (wen_next) begin
         owaddr <= oaddr;
         owdata <= idata ^ ipad;
      end
   end

`ifdef OTP_XOR_CHECKSUM_EN
   logic [3:0] csum_r;

   // Checksum cleared on pass start, folds in each nibble as it is written
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         csum_r <= 4'h0;
      end else if ((state_r == IDLE) && istart) begin
         csum_r <= 4'h0;
      end else if (owrite_en) begin
         csum_r <= csum_r ^ owdata;
      end
   end

   assign ochecksum = csum_r;
`else
   assign ochecksum = 4'h0;
`endif

endmodule
